// File: rtl/bcd_timer_core.sv
// BCD up/down timer with run/pause/adjust control, MM:SS or HH:MM:SS.
// Optional lap capture register enabled by BCD_TIMER_LAP_EN.
module bcd_timer_core #(
    parameter int NUM_FIELDS = 2,
    parameter int TOP_MOD    = 60,
    parameter int SEL_W      = 3
) (
    input  logic                    clk_c,
    input  logic                    reset_c,
    input  logic                    tick_c,
    input  logic                    pause_c,
    input  logic                    ADJ,
    input  logic [SEL_W-1:0]        SEL,
    input  logic [3:0]              NUM,
    input  logic                    load_c,
    input  logic                    dir,
    output logic [8*NUM_FIELDS-1:0] digits_o,
    output logic                    running_o,
    output logic                    wrap_o,
    output logic                    done_o
`ifdef BCD_TIMER_LAP_EN
    ,
    input  logic                    lap_c,
    output logic [8*NUM_FIELDS-1:0] lap_o
`endif
);

    localparam int ND = 2 * NUM_FIELDS;
    localparam int W  = 4 * ND;
    localparam int TF = NUM_FIELDS - 1;
    localparam logic [3:0] TOP_T = 4'((TOP_MOD - 1) / 10);
    localparam logic [3:0] TOP_O = 4'((TOP_MOD - 1) % 10);

    typedef enum logic [1:0] {S_RUN, S_PAUSED, S_ADJUST} state_t;

    state_t state_q, state_d, saved_q, saved_d;
    logic [ND-1:0][3:0] dig_q, dig_d;
    logic [ND-1:0][3:0] inc_v, dec_v, ld_v;
    logic running_q, wrap_q, wrap_d, done_q, done_d;
    logic carry, borrow, roll;
    logic is_zero, is_one;
    logic [7:0] top_val;

    assign is_zero = (dig_q == '0);
    assign is_one  = (dig_q == W'(1));

    always_comb begin
        inc_v = dig_q;
        carry = 1'b1;
        for (int f = 0; f < NUM_FIELDS; f++) begin
            if (carry) begin
                if (f == TF) begin
                    if (dig_q[2*f+1] == TOP_T && dig_q[2*f] == TOP_O) begin
                        inc_v[2*f]   = 4'd0;
                        inc_v[2*f+1] = 4'd0;
                    end else if (dig_q[2*f] == 4'd9) begin
                        inc_v[2*f]   = 4'd0;
                        inc_v[2*f+1] = dig_q[2*f+1] + 4'd1;
                        carry        = 1'b0;
                    end else begin
                        inc_v[2*f] = dig_q[2*f] + 4'd1;
                        carry      = 1'b0;
                    end
                end else if (dig_q[2*f] != 4'd9) begin
                    inc_v[2*f] = dig_q[2*f] + 4'd1;
                    carry      = 1'b0;
                end else begin
                    inc_v[2*f] = 4'd0;
                    if (dig_q[2*f+1] == 4'd5) begin
                        inc_v[2*f+1] = 4'd0;
                    end else begin
                        inc_v[2*f+1] = dig_q[2*f+1] + 4'd1;
                        carry        = 1'b0;
                    end
                end
            end
        end
        roll = carry;
    end

    // Borrow out of the top field is unreachable: all-zero is held.
    always_comb begin
        dec_v  = dig_q;
        borrow = 1'b1;
        for (int f = 0; f < NUM_FIELDS; f++) begin
            if (borrow) begin
                if (dig_q[2*f] != 4'd0) begin
                    dec_v[2*f] = dig_q[2*f] - 4'd1;
                    borrow     = 1'b0;
                end else begin
                    dec_v[2*f] = 4'd9;
                    if (dig_q[2*f+1] != 4'd0) begin
                        dec_v[2*f+1] = dig_q[2*f+1] - 4'd1;
                        borrow       = 1'b0;
                    end else begin
                        dec_v[2*f+1] = (f == TF) ? 4'd9 : 4'd5;
                    end
                end
            end
        end
    end

    always_comb begin
        ld_v = dig_q;
        for (int f = 0; f < NUM_FIELDS; f++) begin
            if (int'(SEL) == 2*f) begin
                ld_v[2*f] = (NUM > 4'd9) ? 4'd9 : NUM;
            end
            if (int'(SEL) == 2*f+1) begin
                if (f == TF) ld_v[2*f+1] = NUM;
                else ld_v[2*f+1] = (NUM > 4'd5) ? 4'd5 : NUM;
            end
        end
        top_val = {4'd0, ld_v[2*TF+1]} * 8'd10 + {4'd0, ld_v[2*TF]};
        if (top_val >= 8'(TOP_MOD)) begin
            ld_v[2*TF+1] = TOP_T;
            ld_v[2*TF]   = TOP_O;
        end
    end

    always_comb begin
        state_d = state_q;
        saved_d = saved_q;
        dig_d   = dig_q;
        wrap_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_RUN: begin
                if (tick_c) begin
                    if (!dir) begin
                        dig_d  = inc_v;
                        wrap_d = roll;
                    end else if (is_zero) begin
                        state_d = S_PAUSED;
                    end else begin
                        dig_d = dec_v;
                        if (is_one) begin
                            done_d  = 1'b1;
                            state_d = S_PAUSED;
                        end
                    end
                end
                if (pause_c) state_d = S_PAUSED;
                if (ADJ) begin
                    saved_d = state_d;
                    state_d = S_ADJUST;
                end
            end
            S_PAUSED: begin
                if (ADJ) begin
                    saved_d = S_PAUSED;
                    state_d = S_ADJUST;
                end else if (pause_c) begin
                    state_d = S_RUN;
                end
            end
            S_ADJUST: begin
                if (load_c) dig_d = ld_v;
                if (!ADJ) state_d = saved_q;
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk_c or negedge reset_c) begin
        if (!reset_c) begin
            state_q   <= S_RUN;
            saved_q   <= S_RUN;
            dig_q     <= '0;
            running_q <= 1'b1;
            wrap_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            saved_q   <= saved_d;
            dig_q     <= dig_d;
            running_q <= (state_d == S_RUN);
            wrap_q    <= wrap_d;
            done_q    <= done_d;
        end
    end

    assign digits_o  = dig_q;
    assign running_o = running_q;
    assign wrap_o    = wrap_q;
    assign done_o    = done_q;

`ifdef BCD_TIMER_LAP_EN
    logic [8*NUM_FIELDS-1:0] lap_q;

    always_ff @(posedge clk_c or negedge reset_c) begin
        if (!reset_c) begin
            lap_q <= '0;
        end else if (lap_c && state_q != S_ADJUST) begin
            lap_q <= dig_q;
        end
    end

    assign lap_o = lap_q;
`endif

endmodule

// File: tb/tb_bcd_timer_core.sv
// Bench for bcd_timer_core: a 2-field/60 and a 3-field/24 instance
// share stimulus and are checked against a total-seconds model.
module tb_bcd_timer_core;

    logic clk = 1'b0;
    logic reset_c = 1'b0;
    logic tick_c = 1'b0, pause_c = 1'b0, adj = 1'b0;
    logic load_c = 1'b0, dir_r = 1'b0;
    logic [2:0] sel = '0;
    logic [3:0] num = '0;
    logic [15:0] d0;
    logic [23:0] d1;
    logic run0, run1, w0, w1, dn0, dn1;
`ifdef BCD_TIMER_LAP_EN
    logic lap_c = 1'b0;
    logic [15:0] lap0;
    logic [23:0] lap1;
`endif

    always #5 clk = ~clk;

    bcd_timer_core #(.NUM_FIELDS(2), .TOP_MOD(60), .SEL_W(3)) u0 (
        .clk_c(clk), .reset_c(reset_c), .tick_c(tick_c),
        .pause_c(pause_c), .ADJ(adj), .SEL(sel), .NUM(num),
        .load_c(load_c), .dir(dir_r), .digits_o(d0),
        .running_o(run0), .wrap_o(w0), .done_o(dn0)
`ifdef BCD_TIMER_LAP_EN
        , .lap_c(lap_c), .lap_o(lap0)
`endif
    );

    bcd_timer_core #(.NUM_FIELDS(3), .TOP_MOD(24), .SEL_W(3)) u1 (
        .clk_c(clk), .reset_c(reset_c), .tick_c(tick_c),
        .pause_c(pause_c), .ADJ(adj), .SEL(sel), .NUM(num),
        .load_c(load_c), .dir(dir_r), .digits_o(d1),
        .running_o(run1), .wrap_o(w1), .done_o(dn1)
`ifdef BCD_TIMER_LAP_EN
        , .lap_c(lap_c), .lap_o(lap1)
`endif
    );

    int n_chk = 0;
    int n_pass = 0;

    // Model: time held as a plain count; 0=RUN 1=PAUSED 2=ADJUST.
    int tot[2], st[2], sv[2], mlap[2];
    bit mw[2], md[2];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic int nf_of(int i);
        return (i == 0) ? 2 : 3;
    endfunction

    function automatic int tm_of(int i);
        return (i == 0) ? 60 : 24;
    endfunction

    function automatic int wgt(int k);
        int w = 1;
        for (int j = 0; j < k; j++) w *= 60;
        return w;
    endfunction

    function automatic int modk(int i, int k);
        return (k == nf_of(i) - 1) ? tm_of(i) : 60;
    endfunction

    function automatic int span(int i);
        return wgt(nf_of(i) - 1) * tm_of(i);
    endfunction

    function automatic logic [23:0] to_bcd(int t, int i);
        logic [23:0] r = '0;
        for (int k = 0; k < nf_of(i); k++) begin
            int v = (t / wgt(k)) % modk(i, k);
            r[8*k +: 4]   = 4'(v % 10);
            r[8*k+4 +: 4] = 4'(v / 10);
        end
        return r;
    endfunction

    function automatic int apply_load(int i, int t);
        int s = int'(sel);
        int n = int'(num);
        int k, v, o, te, nv;
        if (s >= 2 * nf_of(i)) return t;
        k  = s / 2;
        v  = (t / wgt(k)) % modk(i, k);
        o  = v % 10;
        te = v / 10;
        if (s % 2 == 0) o = (n > 9) ? 9 : n;
        else if (k == nf_of(i) - 1) te = n;
        else te = (n > 5) ? 5 : n;
        nv = te * 10 + o;
        if (k == nf_of(i) - 1 && nv >= tm_of(i)) nv = tm_of(i) - 1;
        return t + (nv - v) * wgt(k);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            tot[i] = 0; st[i] = 0; sv[i] = 0;
            mlap[i] = 0; mw[i] = 0; md[i] = 0;
        end
    endtask

    task automatic model_step(input int i);
        int t0 = tot[i];
        int s0 = st[i];
        int base;
        mw[i] = 0;
        md[i] = 0;
`ifdef BCD_TIMER_LAP_EN
        if (lap_c && s0 != 2) mlap[i] = t0;
`endif
        case (s0)
            0: begin
                base = 0;
                if (tick_c) begin
                    if (!dir_r) begin
                        tot[i] = (t0 + 1) % span(i);
                        mw[i] = (tot[i] == 0);
                    end else if (t0 == 0) begin
                        base = 1;
                    end else begin
                        tot[i] = t0 - 1;
                        if (tot[i] == 0) begin
                            md[i] = 1;
                            base = 1;
                        end
                    end
                end
                if (pause_c) base = 1;
                if (adj) begin
                    sv[i] = base;
                    st[i] = 2;
                end else begin
                    st[i] = base;
                end
            end
            1: begin
                if (adj) begin
                    sv[i] = 1;
                    st[i] = 2;
                end else if (pause_c) begin
                    st[i] = 0;
                end
            end
            default: begin
                if (load_c) tot[i] = apply_load(i, t0);
                if (!adj) st[i] = sv[i];
            end
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        chk("dig0", d0, to_bcd(tot[0], 0));
        chk("run0", run0, st[0] == 0);
        chk("wrap0", w0, mw[0]);
        chk("done0", dn0, md[0]);
        chk("dig1", d1, to_bcd(tot[1], 1));
        chk("run1", run1, st[1] == 0);
        chk("wrap1", w1, mw[1]);
        chk("done1", dn1, md[1]);
`ifdef BCD_TIMER_LAP_EN
        chk("lap0", lap0, to_bcd(mlap[0], 0));
        chk("lap1", lap1, to_bcd(mlap[1], 1));
`endif
    endtask

    task automatic cyc(input bit t, input bit p, input bit l,
                       input int s, input int nm);
        tick_c  = t;
        pause_c = p;
        load_c  = l;
        sel     = 3'(s);
        num     = 4'(nm);
        step();
        tick_c  = 1'b0;
        pause_c = 1'b0;
        load_c  = 1'b0;
`ifdef BCD_TIMER_LAP_EN
        lap_c   = 1'b0;
`endif
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dig0", d0, 0);
        chk("rst_run0", run0, 1);
        chk("rst_wrap1", w1, 0);
        chk("rst_done1", dn1, 0);
        @(negedge clk);
        reset_c = 1'b1;

        // 59:58 then two up ticks to rollover
        adj = 1'b1;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 3, 5);
        cyc(0, 0, 1, 2, 9);
        cyc(0, 0, 1, 1, 5);
        cyc(0, 0, 1, 0, 8);
        adj = 1'b0;
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("u0_5959", d0, 16'h5959);
        cyc(1, 0, 0, 0, 0);
        chk("u0_wrap", w0, 1);
        chk("u0_zero", d0, 16'h0000);
        chk("u1_carry", d1, 24'h010000);
        cyc(0, 0, 0, 0, 0);
        chk("u0_wrap_off", w0, 0);

        // 23:59:59 on the 3-field build
        adj = 1'b1;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 5, 2);
        cyc(0, 0, 1, 4, 3);
        cyc(0, 0, 1, 3, 5);
        cyc(0, 0, 1, 2, 9);
        cyc(0, 0, 1, 1, 5);
        cyc(0, 0, 1, 0, 9);
        adj = 1'b0;
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("u1_wrap", w1, 1);
        chk("u1_zero", d1, 24'h000000);
        adj = 1'b1;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 5, 7);
        chk("u1_topclamp", d1, 24'h230000);

        // digit clamps and ignored selects
        cyc(0, 0, 1, 1, 8);
        cyc(0, 0, 1, 0, 12);
        chk("u1_clamp", d1, 24'h230059);
        cyc(0, 0, 1, 7, 3);
        cyc(0, 0, 1, 6, 3);
        chk("u1_sel_ign", d1, 24'h230059);

        // count down 00:02 to terminal stop
        for (int s = 0; s < 6; s++) cyc(0, 0, 1, s, 0);
        cyc(0, 0, 1, 0, 2);
        dir_r = 1'b1;
        adj = 1'b0;
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("cd_one", d0, 16'h0001);
        cyc(1, 0, 0, 0, 0);
        chk("cd_zero", d0, 16'h0000);
        chk("cd_done", dn0, 1);
        chk("cd_paused", run0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("cd_nodone", dn1, 0);

        // pause and tick together from 00:05
        adj = 1'b1;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 5);
        adj = 1'b0;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        dir_r = 1'b0;
        cyc(1, 1, 0, 0, 0);
        chk("pt_dig", d0, 16'h0006);
        chk("pt_run", run0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("pt_hold", d1, 24'h000006);

        // asynchronous reset between edges
        reset_c = 1'b0;
        #2;
        chk("arst_dig", d1, 0);
        chk("arst_run", run1, 1);
        model_reset();
        @(negedge clk);
        reset_c = 1'b1;

`ifdef BCD_TIMER_LAP_EN
        repeat (7) cyc(1, 0, 0, 0, 0);
        lap_c = 1'b1;
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("lap_val", lap0, 16'h0007);
        chk("lap_cnt", d0, 16'h0009);
`endif

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 24) == 0) adj = ~adj;
            if ($urandom_range(0, 15) == 0) dir_r = ~dir_r;
`ifdef BCD_TIMER_LAP_EN
            lap_c = ($urandom_range(0, 9) == 0);
`endif
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0,
                $urandom_range(0, 2) == 0, int'($urandom_range(0, 7)),
                int'($urandom_range(0, 15)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
